cpu_mem_arbiter: RTL

Two-requester arbiter that shares the single CPU memory bus master (the valid/done front end of the AXI-lite/dmem bus master) between port 0 (instruction fetch) and port 1 (load/store unit). It grants round-robin and allows one transaction outstanding at a time. It latches the winning request, launches it downstream as a single-cycle valid pulse, and routes the done pulse and read data back to the granted port. A per-transaction timeout reports a bus error instead of hanging the pipeline.

---
 rtl/cpu_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
// Shares the single CPU memory bus master between instruction fetch (port 0)
// and the load/store unit (port 1). Round-robin grant, one transaction
// outstanding. The winning request is latched and launched as a one-cycle
// m_valid_o pulse. Completion (done + read data) is routed combinationally
// back to the granted port. A per-transaction timeout returns an error
// completion and then drains the late bus response.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   sN_valid_i/wen/addr/wdata/strb requester N (N=0,1) request, held until done
//   sN_rdata_o/done_o/err_o       requester N completion (zero when not done)
//   m_valid_o/wen/addr/wdata/strb launch pulse and latched request to bus master
//   m_rdata_i, m_done_i           bus master response
//   grant_o                       current/last granted port
//   busy_o                        arbiter not idle
module cpu_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s0_valid_i,
  input  logic        s0_wen_i,
  input  logic [31:0] s0_addr_i,
  input  logic [31:0] s0_wdata_i,
  input  logic [3:0]  s0_strb_i,
  output logic [31:0] s0_rdata_o,
  output logic        s0_done_o,
  output logic        s0_err_o,
  input  logic        s1_valid_i,
  input  logic        s1_wen_i,
  input  logic [31:0] s1_addr_i,
  input  logic [31:0] s1_wdata_i,
  input  logic [3:0]  s1_strb_i,
  output logic [31:0] s1_rdata_o,
  output logic        s1_done_o,
  output logic        s1_err_o,
  output logic        m_valid_o,
  output logic        m_wen_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_strb_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_done_i,
  output logic        grant_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DRAIN} state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    TO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_t               state, state_next;
  logic                 last_grant;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 req_any, req_pick;
  logic                 done_ok, timeout_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_any     = s0_valid_i | s1_valid_i;
    // On a tie the port that did not win last time goes next.
    req_pick    = (s0_valid_i & s1_valid_i) ? ~last_grant : s1_valid_i;
    done_ok     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:   if (req_any) state_next = LAUNCH;
      LAUNCH: state_next = BUSY;
      BUSY: begin
        if (m_done_i) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (TO_EN && cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = DRAIN;
        end
      end
      DRAIN:  if (m_done_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    s0_done_o  = (done_ok | timeout_hit) & ~grant_o;
    s1_done_o  = (done_ok | timeout_hit) &  grant_o;
    s0_err_o   = timeout_hit & ~grant_o;
    s1_err_o   = timeout_hit &  grant_o;
    s0_rdata_o = (done_ok & ~grant_o) ? m_rdata_i : '0;
    s1_rdata_o = (done_ok &  grant_o) ? m_rdata_i : '0;
    busy_o     = (state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_o  <= 1'b0;
      m_wen_o    <= 1'b0;
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      m_strb_o   <= '0;
      grant_o    <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      // Registered launch pulse, high exactly while in LAUNCH.
      m_valid_o <= (state_next == LAUNCH);
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_o   <= req_pick;
            m_wen_o   <= req_pick ? s1_wen_i   : s0_wen_i;
            m_addr_o  <= req_pick ? s1_addr_i  : s0_addr_i;
            m_wdata_o <= req_pick ? s1_wdata_i : s0_wdata_i;
            m_strb_o  <= req_pick ? s1_strb_i  : s0_strb_i;
          end
        end
        LAUNCH: cnt <= '0;
        BUSY: begin
          if (!m_done_i) cnt <= cnt + CNT_WIDTH'(1);
          if (done_ok | timeout_hit) last_grant <= grant_o;
        end
        default: ;
      endcase
    end
  end

endmodule
